// File: rtl/dashcam_dma_seq.sv
// -----------------------------------------------------------------------------
// dashcam_dma_seq
//
// Sequencer between the CSR register file and the frame DMA engine. A start
// write latches the buffer base/length; the frame is then cut into bursts of
// at most BURST_WORDS words, each issued through a req/ack/done handshake.
// Progress, sticky status, interrupt status and a frame counter are kept
// here and fed back to the CSR block. Continuous mode re-arms the transfer
// from the current base/length after every completed frame.
//
// Optional feature macro: DASHCAM_DMA_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent in WAIT/ABORTING and ends the
//   transfer after TIMEOUT_CYCLES cycles without a completion. When undefined
//   the block waits indefinitely and status bit [4] reads 0.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ctrl, ctrl_we      control word ([0] start, [1] abort, [2] continuous,
//                      [3] irq_en) and its one-cycle write strobe
//   dma_base, dma_len  buffer byte address / byte length (low 2 bits ignored)
//   irq_clear_pulse    clears sticky status bits [4:1] and irq status
//   burst_req/addr/words, burst_ack, burst_done, burst_err
//                      burst handshake with the DMA engine
//   dma_status_out     {frame_count, 11'b0, timeout, abort, err, done, busy}
//   irq_status_out     {30'b0, err_irq, done_irq}
//   irq_o              registered interrupt line
//   dbg_state          current FSM state (debug observation)
//
// Burst handshake: burst_req acts as a valid. It rises together with
// burst_addr/burst_words and all three stay unchanged until a cycle in which
// burst_ack is high; the request is accepted on that edge and burst_req drops.
// burst_done / burst_err are single-cycle pulses that complete the accepted
// burst; they are only acted on while a burst is outstanding.
// -----------------------------------------------------------------------------
module dashcam_dma_seq #(
  parameter int BURST_WORDS    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ctrl,
  input  logic        ctrl_we,
  input  logic [31:0] dma_base,
  input  logic [31:0] dma_len,
  input  logic        irq_clear_pulse,
  output logic        burst_req,
  output logic [31:0] burst_addr,
  output logic [7:0]  burst_words,
  input  logic        burst_ack,
  input  logic        burst_done,
  input  logic        burst_err,
  output logic [31:0] dma_status_out,
  output logic [31:0] irq_status_out,
  output logic        irq_o,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT     = 3'd2,
    S_ABORTING = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [31:0]  cur_addr_q, cur_addr_d;
  logic [29:0]  remaining_q, remaining_d;
  logic [7:0]   bwords_q, bwords_d;
  logic         req_q, req_d;
  logic         cont_q, cont_d;
  logic         irq_en_q, irq_en_d;
  logic [15:0]  frame_count_q, frame_count_d;
  logic         done_st_q, done_st_d;
  logic         err_st_q, err_st_d;
  logic         abort_st_q, abort_st_d;
  logic         tmo_st_q, tmo_st_d;
  logic         irq_done_q, irq_done_d;
  logic         irq_err_q, irq_err_d;
  logic         irq_o_q, irq_o_d;

  logic         start_wr, abort_wr;
  logic         ev_done, ev_err, ev_abort, ev_tmo;
  logic [29:0]  new_rem, reload_words;
  logic [31:0]  new_addr, reload_addr;
  logic         tmo_hit;

  // Words for the next burst: whatever is left, capped at one full burst.
  function automatic logic [7:0] min_words(input logic [29:0] rem);
    if (rem >= 30'(BURST_WORDS)) return 8'(BURST_WORDS);
    else                          return rem[7:0];
  endfunction

  assign start_wr     = ctrl_we & ctrl[0] & ~ctrl[1];  // abort wins over start
  assign abort_wr     = ctrl_we & ctrl[1];
  assign new_rem      = remaining_q - 30'(bwords_q);
  assign new_addr     = cur_addr_q + {22'd0, bwords_q, 2'b00};
  assign reload_words = dma_len[31:2];
  assign reload_addr  = {dma_base[31:2], 2'b00};

`ifdef DASHCAM_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter restarts whenever WAIT or ABORTING is (re)entered.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_d == state_q) && (state_q == S_WAIT || state_q == S_ABORTING))
      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end
  assign tmo_hit = (state_q == S_WAIT || state_q == S_ABORTING) &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, ctrl[31:4], dma_base[1:0], dma_len[1:0],
                       32'(TIMEOUT_CYCLES)};

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    bwords_d      = bwords_q;
    req_d         = req_q;
    cont_d        = cont_q;
    irq_en_d      = irq_en_q;
    frame_count_d = frame_count_q;
    ev_done       = 1'b0;
    ev_err        = 1'b0;
    ev_abort      = 1'b0;
    ev_tmo        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_wr) begin
          cont_d      = ctrl[2];
          irq_en_d    = ctrl[3];
          cur_addr_d  = reload_addr;
          remaining_d = reload_words;
          if (reload_words == 30'd0) begin
            ev_err = 1'b1;
          end else begin
            state_d  = S_REQ;
            req_d    = 1'b1;
            bwords_d = min_words(reload_words);
          end
        end
      end
      S_REQ: begin
        if (burst_ack) begin
          // Accepted burst must still be drained even if aborted now.
          req_d   = 1'b0;
          state_d = abort_wr ? S_ABORTING : S_WAIT;
        end else if (abort_wr) begin
          req_d    = 1'b0;
          ev_abort = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (burst_err) begin
          ev_err   = 1'b1;
          ev_abort = abort_wr;
          state_d  = S_IDLE;
        end else if (burst_done) begin
          cur_addr_d  = new_addr;
          remaining_d = new_rem;
          if (abort_wr) begin
            ev_abort = 1'b1;
            state_d  = S_IDLE;
          end else if (new_rem == 30'd0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_REQ;
            req_d    = 1'b1;
            bwords_d = min_words(new_rem);
          end
        end else if (tmo_hit) begin
          ev_tmo  = 1'b1;
          state_d = S_IDLE;
        end else if (abort_wr) begin
          state_d = S_ABORTING;
        end
      end
      S_ABORTING: begin
        if (burst_done || burst_err) begin
          ev_abort = 1'b1;
          state_d  = S_IDLE;
        end else if (tmo_hit) begin
          ev_tmo  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        ev_done       = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        if (abort_wr) begin
          ev_abort = 1'b1;
          state_d  = S_IDLE;
        end else if (cont_q) begin
          // Continuous capture re-reads base/length as they are right now.
          cur_addr_d  = reload_addr;
          remaining_d = reload_words;
          if (reload_words == 30'd0) begin
            ev_err  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d  = S_REQ;
            req_d    = 1'b1;
            bwords_d = min_words(reload_words);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Clear first, then OR in this cycle's events so a coincident set wins.
    done_st_d  = (done_st_q  & ~irq_clear_pulse) | ev_done;
    err_st_d   = (err_st_q   & ~irq_clear_pulse) | ev_err | ev_tmo;
    abort_st_d = (abort_st_q & ~irq_clear_pulse) | ev_abort;
    tmo_st_d   = (tmo_st_q   & ~irq_clear_pulse) | ev_tmo;
    irq_done_d = (irq_done_q & ~irq_clear_pulse) | ev_done;
    irq_err_d  = (irq_err_q  & ~irq_clear_pulse) | ev_err | ev_abort | ev_tmo;
    irq_o_d    = irq_en_d & (irq_done_d | irq_err_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      bwords_q      <= '0;
      req_q         <= 1'b0;
      cont_q        <= 1'b0;
      irq_en_q      <= 1'b0;
      frame_count_q <= '0;
      done_st_q     <= 1'b0;
      err_st_q      <= 1'b0;
      abort_st_q    <= 1'b0;
      tmo_st_q      <= 1'b0;
      irq_done_q    <= 1'b0;
      irq_err_q     <= 1'b0;
      irq_o_q       <= 1'b0;
`ifdef DASHCAM_DMA_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      bwords_q      <= bwords_d;
      req_q         <= req_d;
      cont_q        <= cont_d;
      irq_en_q      <= irq_en_d;
      frame_count_q <= frame_count_d;
      done_st_q     <= done_st_d;
      err_st_q      <= err_st_d;
      abort_st_q    <= abort_st_d;
      tmo_st_q      <= tmo_st_d;
      irq_done_q    <= irq_done_d;
      irq_err_q     <= irq_err_d;
      irq_o_q       <= irq_o_d;
`ifdef DASHCAM_DMA_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign burst_req      = req_q;
  assign burst_addr     = cur_addr_q;
  assign burst_words    = bwords_q;
  assign dma_status_out = {frame_count_q, 11'd0, tmo_st_q, abort_st_q,
                           err_st_q, done_st_q, (state_q != S_IDLE)};
  assign irq_status_out = {30'd0, irq_err_q, irq_done_q};
  assign irq_o          = irq_o_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_dashcam_dma_seq.sv
// -----------------------------------------------------------------------------
// tb_dashcam_dma_seq
//
// Bench for dashcam_dma_seq. A behavioural engine model answers burst
// requests with configurable/random ack and done delays. Expected bursts for
// each frame are computed arithmetically and queued; a monitor pops one entry
// per new request. Sticky/irq/frame-count expectations come from a small
// event-level model updated per scenario.
// -----------------------------------------------------------------------------
module tb_dashcam_dma_seq;

  localparam int BW = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] ctrl = '0;
  logic        ctrl_we = 1'b0;
  logic [31:0] dma_base = '0;
  logic [31:0] dma_len = '0;
  logic        irq_clear_pulse;
  logic        clr_main = 1'b0;
  logic        clr_eng = 1'b0;
  logic        burst_req;
  logic [31:0] burst_addr;
  logic [7:0]  burst_words;
  logic        burst_ack = 1'b0;
  logic        burst_done = 1'b0;
  logic        burst_err = 1'b0;
  logic [31:0] dma_status_out;
  logic [31:0] irq_status_out;
  logic        irq_o;
  logic [2:0]  dbg_state;

  assign irq_clear_pulse = clr_main | clr_eng;

  dashcam_dma_seq #(.BURST_WORDS(BW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .ctrl_we(ctrl_we),
    .dma_base(dma_base), .dma_len(dma_len), .irq_clear_pulse(irq_clear_pulse),
    .burst_req(burst_req), .burst_addr(burst_addr), .burst_words(burst_words),
    .burst_ack(burst_ack), .burst_done(burst_done), .burst_err(burst_err),
    .dma_status_out(dma_status_out), .irq_status_out(irq_status_out),
    .irq_o(irq_o), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];   // {addr, words} per expected burst request

  // reference model of status/irq
  logic [15:0] m_frames = '0;
  logic m_done = 0, m_err = 0, m_abort = 0, m_tmo = 0;
  logic m_irq_done = 0, m_irq_err = 0, m_irq_en = 0;

  // engine knobs
  bit eng_busy = 0;
  bit ack_en = 1;
  bit eng_rand = 0;
  int eng_cnt = 0;
  int ack_dly = 1;
  int done_dly = 1;
  int eng_acks = 0;
  int hold_idx = 1000;
  int err_idx = -1;
  int done_seen = 0;
  int clr_done_idx = -1;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- engine model ----------------
  initial begin
    forever begin
      @(negedge clk);
      burst_ack = 0; burst_done = 0; burst_err = 0; clr_eng = 0;
      if (dbg_state == 3'd4) begin
        if (done_seen == clr_done_idx) clr_eng = 1'b1;
        done_seen++;
      end
      if (!eng_busy) begin
        if (burst_req && ack_en) begin
          if (eng_cnt >= ack_dly) begin
            burst_ack = 1; eng_busy = 1; eng_cnt = 0; eng_acks++;
          end else eng_cnt++;
        end else eng_cnt = 0;
      end else if (eng_acks - 1 < hold_idx) begin
        if (eng_cnt >= done_dly) begin
          burst_done = 1;
          if (eng_acks - 1 == err_idx) burst_err = 1;
          eng_busy = 0; eng_cnt = 0;
          if (eng_rand) begin
            ack_dly = $urandom_range(0, 3);
            done_dly = $urandom_range(0, 3);
          end
        end else eng_cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_req = 0;
  logic [39:0] prev_bus = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) prev_req = 0;
      else begin
        if (burst_req && !prev_req) begin
          if (exp_q.size() == 0) chk("unexpected_req", {burst_addr, burst_words}, 40'd0);
          else chk("burst", {burst_addr, burst_words}, exp_q.pop_front());
        end else if (burst_req && prev_req) begin
          chk("req_stable", {burst_addr, burst_words}, prev_bus);
        end
        prev_req = burst_req;
        prev_bus = {burst_addr, burst_words};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    ctrl = v; ctrl_we = 1'b1;
    @(negedge clk);
    ctrl_we = 1'b0;
  endtask

  task automatic do_clear();
    clr_main = 1'b1;
    @(negedge clk);
    clr_main = 1'b0;
    m_done = 0; m_err = 0; m_abort = 0; m_tmo = 0; m_irq_done = 0; m_irq_err = 0;
  endtask

  // Expected bursts of a frame; at most maxn of them.
  task automatic push_frame(input logic [31:0] base, input logic [31:0] len, input int maxn);
    logic [31:0] a;
    int words, w, n;
    a = base & 32'hFFFF_FFFC;
    words = int'(len >> 2);
    n = 0;
    while (words > 0 && n < maxn) begin
      w = (words < BW) ? words : BW;
      exp_q.push_back({a, 8'(w)});
      a = a + 32'(w * 4);
      words -= w;
      n++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (dma_status_out[0] && n < 2000) begin @(negedge clk); n++; end
    chk({name, "_idle"}, 40'(dma_status_out[0]), 40'd0);
  endtask

  task automatic wait_acks(input int target);
    int n = 0;
    while (eng_acks < target && n < 500) begin @(negedge clk); n++; end
    chk("ack_wait", 40'(eng_acks >= target), 40'd1);
  endtask

  task automatic check_status(input string name, input logic busy);
    chk({name, "_status"}, 40'(dma_status_out),
        40'({m_frames, 11'd0, m_tmo, m_abort, m_err, m_done, busy}));
    chk({name, "_irq"}, 40'(irq_status_out), 40'({m_irq_err, m_irq_done}));
    chk({name, "_irq_o"}, 40'(irq_o), 40'(m_irq_en & (m_irq_done | m_irq_err)));
    chk({name, "_expq"}, 40'(exp_q.size()), 40'd0);
  endtask

  // Complete single frame (or zero-length error) with model update.
  task automatic run_frame(input string name, input logic [31:0] base,
                           input logic [31:0] len, input logic ien, input bit scramble);
    do_clear();
    dma_base = base; dma_len = len;
    push_frame(base, len, 1000);
    m_irq_en = ien;
    write_ctrl({28'd0, ien, 3'b001});
    if (scramble) begin dma_base = $urandom; dma_len = $urandom; end
    wait_idle(name);
    if ((len >> 2) == 0) begin m_err = 1; m_irq_err = 1; end
    else begin m_done = 1; m_irq_done = 1; m_frames++; end
    check_status(name, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk);
    cyc(3);
    rst = 1'b0;
    chk("rst_status", 40'(dma_status_out), 40'd0);
    chk("rst_irq", 40'(irq_status_out), 40'd0);
    chk("rst_irq_o", 40'(irq_o), 40'd0);
    chk("rst_req", {7'd0, burst_req, burst_addr}, 40'd0);
    chk("rst_words", 40'(burst_words), 40'd0);

    // four full bursts, fixed 2-cycle ack/done
    ack_dly = 2; done_dly = 2;
    run_frame("f64", 32'h0000_1000, 32'h100, 1'b1, 1'b0);
    chk("f64_status_lit", 40'(dma_status_out), 40'h0_0001_0002);
    do_clear();
    chk("clear_status", 40'(dma_status_out), 40'h0_0001_0000);
    chk("clear_irq_o", 40'(irq_o), 40'd0);

    ack_dly = 1; done_dly = 1;
    run_frame("f11", 32'h0000_2004, 32'h2C, 1'b0, 1'b0);
    run_frame("f1", 32'h0000_3003, 32'h6, 1'b1, 1'b0);
    run_frame("f0", 32'h0000_3100, 32'h3, 1'b0, 1'b0);
    chk("f0_irq_lit", 40'(irq_status_out), 40'h2);

    // error on 2nd burst, coincident with done
    do_clear();
    eng_acks = 0; err_idx = 1;
    dma_base = 32'h4000; dma_len = 32'h100;
    push_frame(32'h4000, 32'h100, 2);
    m_irq_en = 1;
    write_ctrl(32'h9);
    wait_idle("err");
    m_err = 1; m_irq_err = 1;
    check_status("err", 1'b0);
    err_idx = -1;

    // abort while in WAIT
    do_clear();
    eng_acks = 0; hold_idx = 0;
    dma_base = 32'h5000; dma_len = 32'h80;
    push_frame(32'h5000, 32'h80, 1);
    m_irq_en = 0;
    write_ctrl(32'h1);
    wait_acks(1);
    cyc(2);
    write_ctrl(32'h2);
    cyc(1);
    chk("abort_wait_busy", 40'(dma_status_out[0]), 40'd1);
    hold_idx = 1000;
    wait_idle("abw");
    cyc(4);
    m_abort = 1; m_irq_err = 1;
    check_status("abw", 1'b0);

    // abort in REQ before ack
    do_clear();
    ack_en = 0;
    dma_base = 32'h6000; dma_len = 32'h40;
    push_frame(32'h6000, 32'h40, 1);
    write_ctrl(32'h1);
    cyc(1);
    chk("abr_req_hi", 40'(burst_req), 40'd1);
    write_ctrl(32'h2);
    chk("abr_req_lo", 40'(burst_req), 40'd0);
    m_abort = 1; m_irq_err = 1;
    check_status("abr", 1'b0);
    ack_en = 1;

    // continuous: three frames, clear coincident with third done, abort 4th
    do_clear();
    eng_acks = 0; hold_idx = 3; done_seen = 0; clr_done_idx = 2;
    dma_base = 32'h7000; dma_len = 32'h40;
    push_frame(32'h7000, 32'h40, 1); push_frame(32'h7000, 32'h40, 1);
    push_frame(32'h7000, 32'h40, 1); push_frame(32'h7000, 32'h40, 1);
    m_irq_en = 1;
    write_ctrl(32'hD);
    wait_acks(4);
    cyc(2);
    write_ctrl(32'h2);
    hold_idx = 1000;
    wait_idle("cont");
    cyc(4);
    clr_done_idx = -1;
    m_frames += 3; m_done = 1; m_irq_done = 1; m_abort = 1; m_irq_err = 1;
    check_status("cont", 1'b0);

    // randomized frames, with base/len rewritten mid-transfer
    eng_rand = 1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] b, l;
      b = $urandom;
      l = 32'($urandom_range(0, 300));
      run_frame($sformatf("rnd%0d", i), b, l, 1'($urandom_range(0, 1)), 1'b1);
    end
    eng_rand = 0; ack_dly = 1; done_dly = 1;

    // withheld done
    do_clear();
    eng_acks = 0; hold_idx = 0;
    dma_base = 32'h8000; dma_len = 32'h40;
    push_frame(32'h8000, 32'h40, 1);
    m_irq_en = 0;
    write_ctrl(32'h1);
    wait_acks(1);
    cyc(30);
`ifdef DASHCAM_DMA_TIMEOUT_EN
    m_tmo = 1; m_err = 1; m_irq_err = 1;
    check_status("tmo", 1'b0);
    hold_idx = 1000;
    cyc(6);
    check_status("tmo_late", 1'b0);
`else
    check_status("hold", 1'b1);
    write_ctrl(32'h2);
    hold_idx = 1000;
    wait_idle("hold");
    cyc(4);
    m_abort = 1; m_irq_err = 1;
    check_status("hold_end", 1'b0);
`endif

    // reset mid-transfer; late done ignored
    eng_acks = 0; hold_idx = 0;
    dma_base = 32'h9000; dma_len = 32'h40;
    push_frame(32'h9000, 32'h40, 1);
    write_ctrl(32'h9);
    wait_acks(1);
    cyc(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_req", 40'(burst_req), 40'd0);
    hold_idx = 1000;
    cyc(8);
    m_frames = 0; m_done = 0; m_err = 0; m_abort = 0; m_tmo = 0;
    m_irq_done = 0; m_irq_err = 0; m_irq_en = 0;
    check_status("mrst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
